// File: rtl/spi_slave_regfile_ctrl.sv
// ---------------------------------------------------------------------------
// spi_slave_regfile_ctrl
//
// Purpose: SPI mode 3 (CPOL=1, CPHA=1, MSB first) slave front end that owns a
// REG_COUNT x PACK_LENGTH register bank. Each CS-low frame starts with one
// command word: the MSB selects read (1) or write (0) and the remaining bits
// give the start address. Any number of data words follows, and the address
// auto-increments modulo REG_COUNT. The fabric reads the bank in parallel.
//
// Ports:
//   SCLK           SPI clock, idles high. MOSI is sampled on the rising edge
//                  and MISO is updated on the falling edge.
//   IN_RESET       asynchronous, active-high reset of the whole block
//   CS             active-low chip select; a rising edge aborts the frame
//   MOSI / MISO    serial data in / out (MISO is Z while CS is high)
//   IN_STATUS      status word returned while the command word shifts in
//   OUT_REG_FLAT   register i at bits [i*PACK_LENGTH +: PACK_LENGTH]
//   OUT_WR_ADDR    address of the last committed write
//   OUT_WR_TOGGLE  inverts once per committed write (fabric edge-detects it)
//   OUT_ADDR_ERROR sticky out-of-range command flag, cleared by IN_RESET only
// ---------------------------------------------------------------------------
module spi_slave_regfile_ctrl #(
    parameter int PACK_LENGTH = 8,
    parameter int REG_COUNT   = 16,
    parameter int ADDR_W      = $clog2(REG_COUNT)
) (
    input  logic                              SCLK,
    input  logic                              IN_RESET,
    input  logic                              CS,
    input  logic                              MOSI,
    output logic                              MISO,
    input  logic [PACK_LENGTH-1:0]            IN_STATUS,
    output logic [REG_COUNT*PACK_LENGTH-1:0]  OUT_REG_FLAT,
    output logic [ADDR_W-1:0]                 OUT_WR_ADDR,
    output logic                              OUT_WR_TOGGLE,
    output logic                              OUT_ADDR_ERROR
);

    localparam int                     CNT_W       = $clog2(PACK_LENGTH);
    localparam logic [CNT_W-1:0]       LAST_BIT    = CNT_W'(PACK_LENGTH - 1);
    localparam logic [PACK_LENGTH-1:0] REG_COUNT_W = PACK_LENGTH'(REG_COUNT);
    localparam logic [ADDR_W-1:0]      LAST_ADDR   = ADDR_W'(REG_COUNT - 1);

    typedef enum logic [1:0] {
        ST_CMD,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_SKIP
    } state_t;

    // Frame-scoped state is held in reset while CS is high, which gives the
    // asynchronous abort on CS rise. Bank and write-status outputs only
    // respond to IN_RESET, so they survive aborted frames.
    logic frame_rst;
    assign frame_rst = IN_RESET | CS;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [PACK_LENGTH-2:0]   shift_q, shift_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [PACK_LENGTH-1:0]   tx_q, tx_d;

    logic                     first_q;
    logic [PACK_LENGTH-1:0]   status_q;
    logic                     miso_q;

    logic [REG_COUNT*PACK_LENGTH-1:0] bank_flat;
    logic [ADDR_W-1:0]        wr_addr_q;
    logic                     wr_toggle_q;
    logic                     addr_err_q;

    logic [PACK_LENGTH-1:0]   word;
    logic                     word_done;
    logic [ADDR_W-1:0]        cmd_addr;
    logic                     cmd_out_of_range;
    logic                     wr_en;
    logic                     err_set;
    logic [PACK_LENGTH-1:0]   cur_tx_word;
    logic [PACK_LENGTH-1:0]   tx_shifted;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [PACK_LENGTH-1:0] read_bank(
        input logic [REG_COUNT*PACK_LENGTH-1:0] flat,
        input logic [ADDR_W-1:0]                a
    );
        logic [PACK_LENGTH-1:0] r;
        r = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (a == ADDR_W'(i)) begin
                r = flat[i*PACK_LENGTH +: PACK_LENGTH];
            end
        end
        return r;
    endfunction

    // ---------------- receive side: state register ----------------
    always_ff @(posedge SCLK or posedge frame_rst) begin
        if (frame_rst) begin
            state_q   <= ST_CMD;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            tx_q      <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
        end
    end

    // ---------------- receive side: next state ----------------
    always_comb begin
        // The completed word includes the bit arriving on this very edge.
        word             = {shift_q, MOSI};
        word_done        = (bit_cnt_q == LAST_BIT);
        cmd_addr         = word[ADDR_W-1:0];
        cmd_out_of_range = ({1'b0, word[PACK_LENGTH-2:0]} >= REG_COUNT_W);

        state_d   = state_q;
        bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
        shift_d   = word[PACK_LENGTH-2:0];
        addr_d    = addr_q;
        tx_d      = tx_q;
        wr_en     = 1'b0;
        err_set   = 1'b0;

        if (word_done) begin
            case (state_q)
                ST_CMD: begin
                    if (cmd_out_of_range) begin
                        state_d = ST_SKIP;
                        err_set = 1'b1;
                    end else if (word[PACK_LENGTH-1]) begin
                        // Prefetch the first read word now so it is ready
                        // for the very next falling edge.
                        state_d = ST_RD_DATA;
                        tx_d    = read_bank(bank_flat, cmd_addr);
                        addr_d  = next_addr(cmd_addr);
                    end else begin
                        state_d = ST_WR_DATA;
                        addr_d  = cmd_addr;
                    end
                end
                ST_WR_DATA: begin
                    wr_en  = 1'b1;
                    addr_d = next_addr(addr_q);
                end
                ST_RD_DATA: begin
                    tx_d   = read_bank(bank_flat, addr_q);
                    addr_d = next_addr(addr_q);
                end
                default: begin
                    // ST_SKIP: words are consumed and dropped.
                end
            endcase
        end
    end

    // ---------------- register bank ----------------
    generate
        for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_bank
            logic [PACK_LENGTH-1:0] bank_q;
            always_ff @(posedge SCLK or posedge IN_RESET) begin
                if (IN_RESET) begin
                    bank_q <= '0;
                end else if (wr_en && (addr_q == ADDR_W'(gi))) begin
                    bank_q <= word;
                end
            end
            assign bank_flat[gi*PACK_LENGTH +: PACK_LENGTH] = bank_q;
        end
    endgenerate

    always_ff @(posedge SCLK or posedge IN_RESET) begin
        if (IN_RESET) begin
            wr_addr_q   <= '0;
            wr_toggle_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_addr_q   <= addr_q;
                wr_toggle_q <= ~wr_toggle_q;
            end
            if (err_set) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    // ---------------- transmit side (falling SCLK) ----------------
    // During the command word the captured status is shifted out; after it,
    // read frames shift the prefetched word and everything else sends zeros.
    always_comb begin
        cur_tx_word = '0;
        case (state_q)
            ST_CMD:     cur_tx_word = status_q;
            ST_RD_DATA: cur_tx_word = tx_q;
            default:    cur_tx_word = '0;
        endcase
        tx_shifted = cur_tx_word << bit_cnt_q;
    end

    always_ff @(negedge SCLK or posedge frame_rst) begin
        if (frame_rst) begin
            first_q  <= 1'b1;
            status_q <= '0;
            miso_q   <= 1'b0;
        end else if (first_q) begin
            // Status is sampled at the first falling edge and held for the
            // rest of the command word.
            first_q  <= 1'b0;
            status_q <= IN_STATUS;
            miso_q   <= IN_STATUS[PACK_LENGTH-1];
        end else begin
            miso_q   <= tx_shifted[PACK_LENGTH-1];
        end
    end

    assign MISO           = CS ? 1'bz : miso_q;
    assign OUT_REG_FLAT   = bank_flat;
    assign OUT_WR_ADDR    = wr_addr_q;
    assign OUT_WR_TOGGLE  = wr_toggle_q;
    assign OUT_ADDR_ERROR = addr_err_q;

endmodule

// File: tb/tb_spi_slave_regfile_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for spi_slave_regfile_ctrl (PACK_LENGTH=8, REG_COUNT=16).
// The bench plays the SPI master. A frame-level model (array of registers
// plus toggle/address/error bookkeeping) predicts the bank contents and the
// bytes returned on MISO.
// ---------------------------------------------------------------------------
module tb_spi_slave_regfile_ctrl;

    localparam int PL = 8;
    localparam int RC = 16;

    logic          sclk = 1'b1;
    logic          in_reset = 1'b0;
    logic          cs = 1'b1;
    logic          mosi = 1'b0;
    logic [PL-1:0] status = '0;
    wire           miso;
    logic [RC*PL-1:0] flat;
    logic [3:0]    wr_addr;
    logic          tog;
    logic          err;

    spi_slave_regfile_ctrl #(.PACK_LENGTH(PL), .REG_COUNT(RC)) dut (
        .SCLK           (sclk),
        .IN_RESET       (in_reset),
        .CS             (cs),
        .MOSI           (mosi),
        .MISO           (miso),
        .IN_STATUS      (status),
        .OUT_REG_FLAT   (flat),
        .OUT_WR_ADDR    (wr_addr),
        .OUT_WR_TOGGLE  (tog),
        .OUT_ADDR_ERROR (err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [7:0] m_reg [RC];
    logic [3:0] m_wr_addr;
    logic       m_tog;
    logic       m_err;

    // Frame buffers
    logic [7:0] f_tx [16];
    logic [7:0] f_rx [16];
    logic [7:0] e_rx [16];
    int         f_len;

    function automatic logic [RC*PL-1:0] model_flat();
        logic [RC*PL-1:0] v;
        v = '0;
        for (int i = 0; i < RC; i++) v[i*PL +: PL] = m_reg[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RC; i++) m_reg[i] = 8'h00;
        m_wr_addr = 4'd0;
        m_tog     = 1'b0;
        m_err     = 1'b0;
    endtask

    // Frame-level behaviour: status first, then reads/writes/skip by rules.
    task automatic model_frame();
        int a;
        a = int'(f_tx[0][6:0]);
        e_rx[0] = status;
        for (int k = 1; k < f_len; k++) e_rx[k] = 8'h00;
        if (a >= RC) begin
            m_err = 1'b1;
        end else if (f_tx[0][7]) begin
            for (int k = 1; k < f_len; k++) e_rx[k] = m_reg[(a + k - 1) % RC];
        end else begin
            for (int k = 1; k < f_len; k++) begin
                m_reg[a]  = f_tx[k];
                m_wr_addr = 4'(a);
                m_tog     = ~m_tog;
                a         = (a + 1) % RC;
            end
        end
    endtask

    // Shift nbits out MSB-first; MISO is sampled just before the rising edge.
    task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            #2 mosi = b[7-i];
            #3 r = {r[6:0], miso};
            sclk = 1'b1;
            #5;
        end
    endtask

    task automatic do_frame();
        cs = 1'b0;
        #5;
        for (int k = 0; k < f_len; k++) xfer_bits(f_tx[k], 8, f_rx[k]);
        #3 cs = 1'b1;
        #5;
    endtask

    task automatic test_reset();
        in_reset = 1'b1;
        #3 in_reset = 1'b0;
        #2;
        model_reset();
        total++; if (flat !== '0)   begin bad++; $display("FAIL reset_flat got %h want 0", flat); end
        total++; if (wr_addr !== 0) begin bad++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
        total++; if (tog !== 1'b0)  begin bad++; $display("FAIL reset_toggle got %b want 0", tog); end
        total++; if (err !== 1'b0)  begin bad++; $display("FAIL reset_err got %b want 0", err); end
        $display("reset: flat=%h wr_addr=%0d tog=%b err=%b", flat, wr_addr, tog, err);
    endtask

    task automatic test_write_burst();
        logic t0;
        t0 = tog;
        status = 8'($urandom);
        f_len = 3; f_tx[0] = 8'h02; f_tx[1] = 8'hA5; f_tx[2] = 8'h3C;
        model_frame();
        do_frame();
        for (int k = 0; k < f_len; k++) begin
            total++;
            if (f_rx[k] !== e_rx[k]) begin bad++; $display("FAIL write_burst_miso[%0d] got %02h want %02h", k, f_rx[k], e_rx[k]); end
        end
        total++; if (flat !== model_flat()) begin bad++; $display("FAIL write_burst_flat got %h want %h", flat, model_flat()); end
        total++; if (wr_addr !== 4'd3)      begin bad++; $display("FAIL write_burst_wr_addr got %0d want 3", wr_addr); end
        total++; if (tog !== t0)            begin bad++; $display("FAIL write_burst_toggle got %b want %b", tog, t0); end
        $display("write_burst: 02 A5 3C -> miso %02h %02h %02h", f_rx[0], f_rx[1], f_rx[2]);
    endtask

    task automatic test_read_burst();
        status = 8'($urandom);
        f_len = 3; f_tx[0] = 8'h82; f_tx[1] = 8'h00; f_tx[2] = 8'h00;
        model_frame();
        do_frame();
        for (int k = 0; k < f_len; k++) begin
            total++;
            if (f_rx[k] !== e_rx[k]) begin bad++; $display("FAIL read_burst_miso[%0d] got %02h want %02h", k, f_rx[k], e_rx[k]); end
        end
        total++; if (tog !== m_tog) begin bad++; $display("FAIL read_burst_toggle got %b want %b", tog, m_tog); end
        $display("read_burst: 82 00 00 -> miso %02h %02h %02h", f_rx[0], f_rx[1], f_rx[2]);
    endtask

    task automatic test_wrap();
        status = 8'($urandom);
        f_len = 3; f_tx[0] = 8'h0F; f_tx[1] = 8'h11; f_tx[2] = 8'h22;
        model_frame();
        do_frame();
        total++; if (flat !== model_flat()) begin bad++; $display("FAIL wrap_flat got %h want %h", flat, model_flat()); end
        total++; if (wr_addr !== m_wr_addr) begin bad++; $display("FAIL wrap_wr_addr got %0d want %0d", wr_addr, m_wr_addr); end
        $display("wrap: 0F 11 22 -> reg15=%02h reg0=%02h", flat[15*PL +: PL], flat[7:0]);
    endtask

    task automatic test_abort();
        logic [7:0] dummy;
        logic       t0;
        t0 = tog;
        cs = 1'b0;
        #5;
        xfer_bits(8'h01, 8, dummy);
        xfer_bits(8'hA8, 5, dummy);   // 1,0,1,0,1
        #3 cs = 1'b1;
        #5;
        total++; if (flat !== model_flat()) begin bad++; $display("FAIL abort_flat got %h want %h", flat, model_flat()); end
        total++; if (tog !== t0)            begin bad++; $display("FAIL abort_toggle got %b want %b", tog, t0); end
        status = 8'($urandom);
        f_len = 2; f_tx[0] = 8'h81; f_tx[1] = 8'h00;
        model_frame();
        do_frame();
        total++; if (f_rx[1] !== e_rx[1]) begin bad++; $display("FAIL abort_readback got %02h want %02h", f_rx[1], e_rx[1]); end
        $display("abort: reg1 readback %02h", f_rx[1]);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            status  = 8'($urandom);
            f_len   = 1 + int'($urandom_range(0, 5));
            f_tx[0] = {1'($urandom), 3'b000, 4'($urandom_range(0, RC-1))};
            for (int k = 1; k < f_len; k++) f_tx[k] = 8'($urandom);
            model_frame();
            do_frame();
            for (int k = 0; k < f_len; k++) begin
                total++;
                if (f_rx[k] !== e_rx[k]) begin bad++; $display("FAIL random%0d_miso[%0d] got %02h want %02h", n, k, f_rx[k], e_rx[k]); end
            end
            total++; if (flat !== model_flat()) begin bad++; $display("FAIL random%0d_flat got %h want %h", n, flat, model_flat()); end
            total++; if (tog !== m_tog)         begin bad++; $display("FAIL random%0d_toggle got %b want %b", n, tog, m_tog); end
            total++; if (wr_addr !== m_wr_addr) begin bad++; $display("FAIL random%0d_wr_addr got %0d want %0d", n, wr_addr, m_wr_addr); end
            $display("random%0d: cmd=%02h len=%0d status=%02h", n, f_tx[0], f_len, status);
        end
    endtask

    task automatic test_out_of_range();
        status = 8'($urandom);
        f_len = 2; f_tx[0] = 8'h20; f_tx[1] = 8'h55;
        model_frame();
        do_frame();
        total++; if (err !== 1'b1)          begin bad++; $display("FAIL oor_err got %b want 1", err); end
        total++; if (flat !== model_flat()) begin bad++; $display("FAIL oor_flat got %h want %h", flat, model_flat()); end
        total++; if (f_rx[1] !== e_rx[1])   begin bad++; $display("FAIL oor_miso got %02h want %02h", f_rx[1], e_rx[1]); end
        f_len = 2; f_tx[0] = 8'h03; f_tx[1] = 8'h99;
        model_frame();
        do_frame();
        total++; if (err !== m_err)         begin bad++; $display("FAIL oor_sticky got %b want %b", err, m_err); end
        total++; if (flat !== model_flat()) begin bad++; $display("FAIL oor_after_flat got %h want %h", flat, model_flat()); end
        $display("out_of_range: err=%b", err);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] dummy;
        cs = 1'b0;
        #5;
        xfer_bits(8'h04, 8, dummy);
        xfer_bits(8'h66, 8, dummy);
        xfer_bits(8'hF0, 3, dummy);
        in_reset = 1'b1;
        #2 in_reset = 1'b0;
        #2;
        model_reset();
        total++; if (flat !== '0)   begin bad++; $display("FAIL midrst_flat got %h want 0", flat); end
        total++; if (tog !== 1'b0)  begin bad++; $display("FAIL midrst_toggle got %b want 0", tog); end
        total++; if (wr_addr !== 0) begin bad++; $display("FAIL midrst_wr_addr got %0d want 0", wr_addr); end
        total++; if (err !== 1'b0)  begin bad++; $display("FAIL midrst_err got %b want 0", err); end
        // CS stays low: the next 8 bits must be a fresh command word.
        f_len = 2; f_tx[0] = 8'h06; f_tx[1] = 8'h5A;
        model_frame();
        xfer_bits(f_tx[0], 8, dummy);
        xfer_bits(f_tx[1], 8, dummy);
        #3 cs = 1'b1;
        #5;
        total++; if (flat !== model_flat()) begin bad++; $display("FAIL midrst_cmd_flat got %h want %h", flat, model_flat()); end
        total++; if (tog !== m_tog)         begin bad++; $display("FAIL midrst_cmd_toggle got %b want %b", tog, m_tog); end
        total++; if (wr_addr !== m_wr_addr) begin bad++; $display("FAIL midrst_cmd_wr_addr got %0d want %0d", wr_addr, m_wr_addr); end
        $display("reset_mid_frame: reg6=%02h tog=%b", flat[6*PL +: PL], tog);
    endtask

    initial begin
        model_reset();
        #10;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_abort();
        test_random();
        test_out_of_range();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
